rambus_arbiter: RTL and testbench

//  Two-port Wishbone arbiter/sequencer in front of the 32-bit SRAM bank (four
//  gf180mcu 512x8 macros, one per byte lane). Shares the bank between the

---
 rtl/rambus_arbiter.sv | 148 ++++++++++++++
 tb/tb_rambus_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/rambus_arbiter.sv
// Two-port round-robin Wishbone arbiter sequencing a 32-bit bank of four 512x8
// SRAM macros through a fixed IDLE/ACCESS/RESP/ACK cycle with a registered ack.
module rambus_arbiter #(
  parameter int AW = 9,
  parameter int DW = 32
) (
  input  logic          rambus_wb_clk_i,
  input  logic          rambus_wb_rst_i,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [3:0]    m0_sel_i,
  input  logic [AW-1:0] m0_addr_i,
  input  logic [DW-1:0] m0_dat_i,
  output logic          m0_ack_o,
  output logic [DW-1:0] m0_dat_o,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [3:0]    m1_sel_i,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [DW-1:0] m1_dat_i,
  output logic          m1_ack_o,
  output logic [DW-1:0] m1_dat_o,
  output logic          sram_cen_o,
  output logic          sram_gwen_o,
  output logic [DW-1:0] sram_wen_o,
  output logic [AW-1:0] sram_a_o,
  output logic [DW-1:0] sram_d_o,
  input  logic [DW-1:0] sram_q_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, ACK} state_t;

  state_t        state, state_nxt;
  logic          grant, grant_nxt;
  logic          last_grant, last_grant_nxt;
  logic          gnt_we, gnt_we_nxt;
  logic          cen_nxt, gwen_nxt;
  logic [DW-1:0] wen_nxt, d_nxt, dat0_nxt, dat1_nxt;
  logic [AW-1:0] a_nxt;
  logic          ack0_nxt, ack1_nxt;

  logic          req0, req1, pick;
  logic          pick_we, gnt_cyc;
  logic [3:0]    pick_sel;
  logic [AW-1:0] pick_addr;
  logic [DW-1:0] pick_dat;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

  // Contested requests go to the port that did not win last time.
  assign pick      = (req0 & req1) ? ~last_grant : req1;
  assign pick_we   = pick ? m1_we_i   : m0_we_i;
  assign pick_sel  = pick ? m1_sel_i  : m0_sel_i;
  assign pick_addr = pick ? m1_addr_i : m0_addr_i;
  assign pick_dat  = pick ? m1_dat_i  : m0_dat_i;
  assign gnt_cyc   = grant ? m1_cyc_i : m0_cyc_i;

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    gnt_we_nxt     = gnt_we;
    cen_nxt        = sram_cen_o;
    gwen_nxt       = sram_gwen_o;
    wen_nxt        = sram_wen_o;
    a_nxt          = sram_a_o;
    d_nxt          = sram_d_o;
    ack0_nxt       = 1'b0;
    ack1_nxt       = 1'b0;
    dat0_nxt       = m0_dat_o;
    dat1_nxt       = m1_dat_o;
    case (state)
      IDLE: begin
        if (req0 | req1) begin
          grant_nxt      = pick;
          last_grant_nxt = pick;
          gnt_we_nxt     = pick_we;
          cen_nxt        = 1'b0;
          gwen_nxt       = ~pick_we;
          for (int k = 0; k < 4; k++)
            wen_nxt[8*k +: 8] = {8{~(pick_we & pick_sel[k])}};
          a_nxt          = pick_addr;
          d_nxt          = pick_dat;
          state_nxt      = ACCESS;
        end
      end
      ACCESS: begin
        cen_nxt   = 1'b1;
        gwen_nxt  = 1'b1;
        wen_nxt   = '1;
        state_nxt = RESP;
      end
      RESP: begin
        // A master that dropped cyc gets no ack; its write has already committed.
        if (gnt_cyc) begin
          if (grant) begin
            ack1_nxt = 1'b1;
            if (!gnt_we) dat1_nxt = sram_q_i;
          end else begin
            ack0_nxt = 1'b1;
            if (!gnt_we) dat0_nxt = sram_q_i;
          end
          state_nxt = ACK;
        end else begin
          state_nxt = IDLE;
        end
      end
      ACK: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rambus_wb_clk_i) begin
    if (rambus_wb_rst_i) begin
      state       <= IDLE;
      grant       <= 1'b0;
      last_grant  <= 1'b1;
      gnt_we      <= 1'b0;
      sram_cen_o  <= 1'b1;
      sram_gwen_o <= 1'b1;
      sram_wen_o  <= '1;
      sram_a_o    <= '0;
      sram_d_o    <= '0;
      m0_ack_o    <= 1'b0;
      m1_ack_o    <= 1'b0;
      m0_dat_o    <= '0;
      m1_dat_o    <= '0;
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      last_grant  <= last_grant_nxt;
      gnt_we      <= gnt_we_nxt;
      sram_cen_o  <= cen_nxt;
      sram_gwen_o <= gwen_nxt;
      sram_wen_o  <= wen_nxt;
      sram_a_o    <= a_nxt;
      sram_d_o    <= d_nxt;
      m0_ack_o    <= ack0_nxt;
      m1_ack_o    <= ack1_nxt;
      m0_dat_o    <= dat0_nxt;
      m1_dat_o    <= dat1_nxt;
    end
  end

endmodule

// File: tb/tb_rambus_arbiter.sv
// Directed and randomized bench for rambus_arbiter against a word-level memory
// model with round-robin grant order and fixed ack latency.
module tb_rambus_arbiter;
  localparam int AW = 9;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          m0_cyc, m0_stb, m0_we, m0_ack;
  logic [3:0]    m0_sel;
  logic [AW-1:0] m0_addr;
  logic [31:0]   m0_wd, m0_rd;
  logic          m1_cyc, m1_stb, m1_we, m1_ack;
  logic [3:0]    m1_sel;
  logic [AW-1:0] m1_addr;
  logic [31:0]   m1_wd, m1_rd;
  logic          sram_cen, sram_gwen;
  logic [31:0]   sram_wen, sram_d, sram_q;
  logic [AW-1:0] sram_a;

  rambus_arbiter #(.AW(AW), .DW(32)) dut (
    .rambus_wb_clk_i(clk), .rambus_wb_rst_i(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_addr_i(m0_addr), .m0_dat_i(m0_wd), .m0_ack_o(m0_ack), .m0_dat_o(m0_rd),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_addr_i(m1_addr), .m1_dat_i(m1_wd), .m1_ack_o(m1_ack), .m1_dat_o(m1_rd),
    .sram_cen_o(sram_cen), .sram_gwen_o(sram_gwen), .sram_wen_o(sram_wen),
    .sram_a_o(sram_a), .sram_d_o(sram_d), .sram_q_i(sram_q)
  );

  // Macro bank: samples pins at the edge, per-bit active-low write, q next cycle.
  logic [31:0] mem [0:511];
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      sram_q <= mem[sram_a];
    end
  end

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0]   ref_mem [0:511];
  logic          ref_last;
  logic [31:0]   ref_dat [2];
  logic          op_act  [2];
  logic          op_we   [2];
  logic [3:0]    op_sel  [2];
  logic [AW-1:0] op_addr [2];
  logic [31:0]   op_wd   [2];
  logic [31:0]   issue_wen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] sel);
    merge = old;
    for (int k = 0; k < 4; k++) if (sel[k]) merge[8*k +: 8] = wd[8*k +: 8];
  endfunction

  task automatic set_port(input int p, input logic on);
    if (p == 0) begin
      m0_cyc = on; m0_stb = on; m0_we = op_we[0]; m0_sel = op_sel[0];
      m0_addr = op_addr[0]; m0_wd = op_wd[0];
    end else begin
      m1_cyc = on; m1_stb = on; m1_we = op_we[1]; m1_sel = op_sel[1];
      m1_addr = op_addr[1]; m1_wd = op_wd[1];
    end
  endtask

  task automatic set_op(input int p, input logic we, input logic [3:0] sel,
                        input logic [AW-1:0] addr, input logic [31:0] wd);
    op_act[p] = 1'b1; op_we[p] = we; op_sel[p] = sel; op_addr[p] = addr; op_wd[p] = wd;
  endtask

  task automatic clr_ops();
    op_act[0] = 1'b0; op_act[1] = 1'b0;
  endtask

  // Issue the active ops together; the model decides grant order and expectations.
  task automatic run_ops();
    int order[$];
    int exp_lat[2];
    logic [31:0] exp_rd[2];
    bit done[2];
    int cyc_n, cen_lo;
    logic ack;
    logic [31:0] rd;
    if (op_act[0] && op_act[1]) begin
      order.push_back(ref_last ? 0 : 1);
      order.push_back(ref_last ? 1 : 0);
    end else if (op_act[0]) order.push_back(0);
    else if (op_act[1]) order.push_back(1);
    exp_lat[0] = -1; exp_lat[1] = -1;
    exp_rd[0] = ref_dat[0]; exp_rd[1] = ref_dat[1];
    foreach (order[i]) begin
      int p = order[i];
      exp_lat[p] = 3 + 4 * i;
      if (op_we[p]) ref_mem[op_addr[p]] = merge(ref_mem[op_addr[p]], op_wd[p], op_sel[p]);
      else ref_dat[p] = ref_mem[op_addr[p]];
      exp_rd[p] = ref_dat[p];
      ref_last = p[0];
    end
    @(negedge clk);
    for (int p = 0; p < 2; p++) if (op_act[p]) set_port(p, 1'b1);
    done[0] = !op_act[0]; done[1] = !op_act[1];
    cyc_n = 0; cen_lo = 0;
    while (!(done[0] && done[1]) && cyc_n < 16) begin
      @(negedge clk);
      cyc_n++;
      if (cyc_n == 1) issue_wen = sram_wen;
      if (!sram_cen) cen_lo++;
      chk("acks_exclusive", {31'd0, m0_ack & m1_ack}, 32'd0);
      for (int p = 0; p < 2; p++) begin
        ack = p ? m1_ack : m0_ack;
        rd  = p ? m1_rd : m0_rd;
        if (ack) begin
          chk(p ? "m1_ack_latency" : "m0_ack_latency", cyc_n, exp_lat[p]);
          chk(p ? "m1_rdata" : "m0_rdata", rd, exp_rd[p]);
          done[p] = 1'b1;
          set_port(p, 1'b0);
        end
      end
    end
    for (int p = 0; p < 2; p++)
      if (!done[p]) begin
        chk("ack_timeout", {31'd0, done[p]}, 32'd1);
        set_port(p, 1'b0);
      end
    chk("cen_low_cycles", cen_lo, order.size());
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    ref_last = 1'b1; ref_dat[0] = '0; ref_dat[1] = '0;
    clr_ops();
    op_we[0] = 0; op_we[1] = 0; op_sel[0] = 0; op_sel[1] = 0;
    op_addr[0] = 0; op_addr[1] = 0; op_wd[0] = 0; op_wd[1] = 0;
    set_port(0, 1'b0); set_port(1, 1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cen", {31'd0, sram_cen}, 32'd1);
    chk("rst_gwen", {31'd0, sram_gwen}, 32'd1);
    chk("rst_wen", sram_wen, 32'hFFFF_FFFF);
    chk("rst_a", {23'd0, sram_a}, 32'd0);
    chk("rst_d", sram_d, 32'd0);
    chk("rst_acks", {30'd0, m0_ack, m1_ack}, 32'd0);
    chk("rst_dat0", m0_rd, 32'd0);
    chk("rst_dat1", m1_rd, 32'd0);
    rst = 1'b0;

    // m0 write then read back
    clr_ops(); set_op(0, 1'b1, 4'hF, 9'h005, 32'hA5A5_1234); run_ops();
    chk("t1_write_wen", issue_wen, 32'h0000_0000);
    clr_ops(); set_op(0, 1'b0, 4'hF, 9'h005, 32'h0); run_ops();
    chk("t1_read", m0_rd, 32'hA5A5_1234);

    // m1 single-lane write over all-ones
    clr_ops(); set_op(1, 1'b1, 4'hF, 9'h1FF, 32'hFFFF_FFFF); run_ops();
    clr_ops(); set_op(1, 1'b1, 4'h2, 9'h1FF, 32'h0000_CD00); run_ops();
    chk("t2_write_wen", issue_wen, 32'hFFFF_00FF);
    clr_ops(); set_op(1, 1'b0, 4'hF, 9'h1FF, 32'h0); run_ops();
    chk("t2_read", m1_rd, 32'hFFFF_CDFF);

    // Reset restores last_grant so m0 wins the first contest
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    ref_last = 1'b1; ref_dat[0] = '0; ref_dat[1] = '0;
    for (int r = 0; r < 2; r++) begin
      clr_ops();
      set_op(0, 1'b0, 4'hF, 9'h005, 32'h0);
      set_op(1, 1'b0, 4'hF, 9'h1FF, 32'h0);
      run_ops();
    end
    chk("t3_m0_data", m0_rd, 32'hA5A5_1234);
    chk("t3_m1_data", m1_rd, 32'hFFFF_CDFF);

    // m1 drops cyc during ACCESS of a write
    clr_ops(); set_op(1, 1'b1, 4'hF, 9'h010, 32'h1111_1111);
    ref_mem[9'h010] = 32'h1111_1111; ref_last = 1'b1;
    @(negedge clk); set_port(1, 1'b1);
    @(negedge clk); set_port(1, 1'b0);
    for (int i = 0; i < 5; i++) chk("t4_no_ack", {30'd0, m0_ack, m1_ack}, 32'd0) ;
    repeat (5) begin
      @(negedge clk);
      chk("t4_no_ack_cycle", {30'd0, m0_ack, m1_ack}, 32'd0);
    end
    clr_ops(); set_op(0, 1'b0, 4'hF, 9'h010, 32'h0); run_ops();
    chk("t4_read", m0_rd, 32'h1111_1111);

    // Reset during RESP of a read
    clr_ops(); set_op(0, 1'b0, 4'hF, 9'h005, 32'h0);
    @(negedge clk); set_port(0, 1'b1);
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("t5_acks", {30'd0, m0_ack, m1_ack}, 32'd0);
    chk("t5_cen", {31'd0, sram_cen}, 32'd1);
    chk("t5_gwen", {31'd0, sram_gwen}, 32'd1);
    chk("t5_wen", sram_wen, 32'hFFFF_FFFF);
    chk("t5_a", {23'd0, sram_a}, 32'd0);
    chk("t5_dat0", m0_rd, 32'd0);
    rst = 1'b0; set_port(0, 1'b0);
    ref_last = 1'b1; ref_dat[0] = '0; ref_dat[1] = '0;
    @(negedge clk);
    chk("t5_no_late_ack", {30'd0, m0_ack, m1_ack}, 32'd0);
    clr_ops(); set_op(0, 1'b0, 4'hF, 9'h005, 32'h0); run_ops();
    chk("t5_read", m0_rd, 32'hA5A5_1234);

    // Randomized mixed traffic
    for (int n = 0; n < 1000; n++) begin
      int mode;
      mode = $urandom_range(0, 2);
      clr_ops();
      for (int p = 0; p < 2; p++) begin
        if (mode == 2 || mode == p) begin
          logic [AW-1:0] a;
          a = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
          set_op(p, 1'($urandom), 4'($urandom), a, $urandom);
        end
      end
      run_ops();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
